// File: rtl/imem_fetch_if.sv
// Fetch request/response handshake bundle shared by imem_fetch and its requester.
interface imem_fetch_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_fetch.sv
// Instruction memory with a one-outstanding fetch port and a program-load write port.
// Optional IMEM_FETCH_FLUSH_EN adds a flush input that drops the outstanding fetch.
module imem_fetch #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  imem_fetch_if.slave       bus,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
`ifdef IMEM_FETCH_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [2:0]      CNT_LOAD = 3'((LATENCY > 1) ? (LATENCY - 2) : 0);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_data_q;

  logic flush_w;
  logic accept;
  logic rd_in_range;
  logic wr_in_range;

`ifdef IMEM_FETCH_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign rd_in_range = {1'b0, bus.req_addr} < DEPTH_L;
  assign wr_in_range = {1'b0, waddr} < DEPTH_L;

  // A flush in IDLE must block the accept, so it masks req_ready directly.
  assign bus.req_ready = (state_q == IDLE) && !flush_w;
  assign accept        = bus.req_valid && bus.req_ready;

  // Memory array kept free of reset so it maps onto block RAM; nonblocking
  // write gives read-before-write when both hit the same word.
  always_ff @(posedge clk) begin
    if (we && wr_in_range) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && rd_in_range) begin
      rd_data_q <= mem[bus.req_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = !rd_in_range;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        err_d   = 1'b0;
      end
    endcase
    if (flush_w && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      err_d   = 1'b0;
    end
  end

  // Outputs are zeroed outside RESP, which also hides the unreset read register.
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.rsp_data  = ((state_q == RESP) && !err_q) ? rd_data_q : '0;

endmodule
